// File: rtl/qdec_pkg.sv
// Shared quadrature decode definitions: Gray-code state names, step result payload and the step classifier.
package qdec_pkg;

  localparam logic [1:0] QST_00 = 2'b00;
  localparam logic [1:0] QST_01 = 2'b01;
  localparam logic [1:0] QST_11 = 2'b11;
  localparam logic [1:0] QST_10 = 2'b10;

  localparam int unsigned STAB_W = 4;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } qdec_step_t;

  // Classify a filtered {B,A} transition; forward order is 00->01->11->10->00.
  function automatic qdec_step_t qdec_step(input logic [1:0] prev, input logic [1:0] cur);
    qdec_step_t s;
    logic [1:0] fwd;
    s = '0;
    case (prev)
      QST_00:  fwd = QST_01;
      QST_01:  fwd = QST_11;
      QST_11:  fwd = QST_10;
      default: fwd = QST_00;
    endcase
    if ((prev ^ cur) == 2'b11) begin
      s.illegal = 1'b1;
    end else if (prev != cur) begin
      s.valid = 1'b1;
      s.up    = (cur == fwd);
    end
    return s;
  endfunction

endpackage

// File: rtl/qdec_channel.sv
// One quadrature channel: 2-flop sync, stability filter, registered decode and wrap/saturate counter
// with sticky overflow and illegal-transition flags.
module qdec_channel
  import qdec_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned INIT     = 128,
  parameter int unsigned SAT      = 0
) (
  input  logic             clk_62p5mhz,
  input  logic             reset_,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             dir,
  output logic             ovf,
  output logic             err
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(INIT);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_LEN - 1);
  localparam bit                SAT_MODE  = (SAT != 0);

  logic [1:0]        sync1, sync2, sync_prev, filt, filt_d;
  logic [STAB_W-1:0] stab, stab_nxt;
  qdec_step_t        step_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_hit;

  // stab counts consecutive samples of the current synced value (0 = first sample)
  always_comb begin
    stab_nxt = stab;
    if (sync2 != sync_prev) begin
      stab_nxt = '0;
    end else if (stab != STAB_LAST) begin
      stab_nxt = stab + STAB_W'(1);
    end
  end

  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      stab      <= '0;
      filt      <= QST_00;
      filt_d    <= QST_00;
      step_q    <= '0;
    end else begin
      sync1     <= {quad_b, quad_a};
      sync2     <= sync1;
      sync_prev <= sync2;
      stab      <= stab_nxt;
      if (stab_nxt == STAB_LAST) begin
        filt <= sync2;
      end
      filt_d    <= filt;
      step_q    <= qdec_step(filt_d, filt);
    end
  end

  // Next counter value for the registered step, clipping or wrapping at the ends
  always_comb begin
    cnt_nxt = cnt;
    ovf_hit = 1'b0;
    if (step_q.up) begin
      if (cnt == CNT_MAX) begin
        ovf_hit = 1'b1;
        cnt_nxt = SAT_MODE ? CNT_MAX : '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else begin
      if (cnt == '0) begin
        ovf_hit = 1'b1;
        cnt_nxt = SAT_MODE ? '0 : CNT_MAX;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      cnt <= CNT_INIT;
      dir <= 1'b0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else if (clr) begin
      cnt <= CNT_INIT;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (step_q.valid) begin
        cnt <= cnt_nxt;
        dir <= step_q.up;
        if (ovf_hit) begin
          ovf <= 1'b1;
        end
      end
      if (step_q.illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder_array.sv
// NCH-channel quadrature decoder array with a shared snapshot bank so all channels are captured
// in the same cycle.
module quad_decoder_array
  import qdec_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned INIT     = 128,
  parameter int unsigned SAT      = 0
) (
  input  logic                 clk_62p5mhz,
  input  logic                 reset_,
  input  logic [NCH-1:0]       quad_a,
  input  logic [NCH-1:0]       quad_b,
  input  logic [NCH-1:0]       clr,
  input  logic                 snap,
  output logic [NCH*CNT_W-1:0] cnt_live,
  output logic [NCH*CNT_W-1:0] cnt_snap,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       err
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    qdec_channel #(
      .CNT_W   (CNT_W),
      .FILT_LEN(FILT_LEN),
      .INIT    (INIT),
      .SAT     (SAT)
    ) u_ch (
      .clk_62p5mhz(clk_62p5mhz),
      .reset_     (reset_),
      .quad_a     (quad_a[i]),
      .quad_b     (quad_b[i]),
      .clr        (clr[i]),
      .cnt        (cnt_live[i*CNT_W +: CNT_W]),
      .dir        (dir[i]),
      .ovf        (ovf[i]),
      .err        (err[i])
    );
  end

  // Snapshot samples the pre-update live counters, so same-cycle steps/clears are excluded
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      cnt_snap <= {NCH{CNT_W'(INIT)}};
    end else if (snap) begin
      cnt_snap <= cnt_live;
    end
  end

endmodule

// File: tb/tb_quad_decoder_array.sv
// Self-checking bench: three decoder arrays (wrap/INIT=128, wrap/INIT=254, saturate/INIT=254)
// share stimulus and are compared against a position-arithmetic reference model.
module tb_quad_decoder_array;

  localparam int NCH      = 2;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 4;
  localparam int MAXV     = (1 << CNT_W) - 1;
  localparam int ND       = 3;

  logic clk = 1'b0;
  logic reset_;
  logic [NCH-1:0] qa, qb, clr;
  logic snap;

  logic [NCH*CNT_W-1:0] live [ND];
  logic [NCH*CNT_W-1:0] snapv [ND];
  logic [NCH-1:0] dirv [ND];
  logic [NCH-1:0] ovfv [ND];
  logic [NCH-1:0] errv [ND];

  int errors = 0;
  int checks = 0;

  int init_v [ND];
  int sat_v  [ND];
  int m_cnt  [ND][NCH];
  int m_snap [ND][NCH];
  int m_dir  [ND][NCH];
  int m_ovf  [ND][NCH];
  int m_err  [ND][NCH];
  logic [1:0] m_st [NCH];

  logic [1:0] up_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  int wrap_exp [3] = '{255, 0, 1};

  always #8 clk = ~clk;

  quad_decoder_array #(.NCH(NCH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .INIT(128), .SAT(0)) u_dut (
    .clk_62p5mhz(clk), .reset_(reset_), .quad_a(qa), .quad_b(qb), .clr(clr), .snap(snap),
    .cnt_live(live[0]), .cnt_snap(snapv[0]), .dir(dirv[0]), .ovf(ovfv[0]), .err(errv[0]));

  quad_decoder_array #(.NCH(NCH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .INIT(254), .SAT(0)) u_wrap (
    .clk_62p5mhz(clk), .reset_(reset_), .quad_a(qa), .quad_b(qb), .clr(clr), .snap(snap),
    .cnt_live(live[1]), .cnt_snap(snapv[1]), .dir(dirv[1]), .ovf(ovfv[1]), .err(errv[1]));

  quad_decoder_array #(.NCH(NCH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .INIT(254), .SAT(1)) u_sat (
    .clk_62p5mhz(clk), .reset_(reset_), .quad_a(qa), .quad_b(qb), .clr(clr), .snap(snap),
    .cnt_live(live[2]), .cnt_snap(snapv[2]), .dir(dirv[2]), .ovf(ovfv[2]), .err(errv[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Position of a {B,A} state along the forward rotation
  function automatic int qpos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[d][c] = init_v[d]; m_snap[d][c] = init_v[d];
        m_dir[d][c] = 0; m_ovf[d][c] = 0; m_err[d][c] = 0;
      end
    for (int c = 0; c < NCH; c++) m_st[c] = 2'b00;
  endtask

  task automatic model_move(input int ch, input logic [1:0] ns);
    int delta;
    int nc;
    delta = (qpos(ns) - qpos(m_st[ch]) + 4) % 4;
    for (int d = 0; d < ND; d++) begin
      if (delta == 2) begin
        m_err[d][ch] = 1;
      end else if (delta != 0) begin
        nc = m_cnt[d][ch] + ((delta == 1) ? 1 : -1);
        if (nc < 0 || nc > MAXV) begin
          m_ovf[d][ch] = 1;
          if (sat_v[d] != 0) nc = (nc < 0) ? 0 : MAXV;
          else               nc = (nc + MAXV + 1) % (MAXV + 1);
        end
        m_cnt[d][ch] = nc;
        m_dir[d][ch] = (delta == 1) ? 1 : 0;
      end
    end
    m_st[ch] = ns;
  endtask

  task automatic model_clr(input int mask);
    for (int c = 0; c < NCH; c++)
      if (((mask >> c) & 1) != 0)
        for (int d = 0; d < ND; d++) begin
          m_cnt[d][c] = init_v[d]; m_ovf[d][c] = 0; m_err[d][c] = 0;
        end
  endtask

  task automatic model_snap();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NCH; c++) m_snap[d][c] = m_cnt[d][c];
  endtask

  task automatic set_ch(input int ch, input logic [1:0] st);
    qa[ch] = st[0];
    qb[ch] = st[1];
  endtask

  task automatic pulse_clr(input logic [NCH-1:0] m);
    clr = m;
    tick(1);
    clr = '0;
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("%s d%0d ch%0d live", tag, d, c), 32'(live[d][c*CNT_W +: CNT_W]), m_cnt[d][c]);
        chk($sformatf("%s d%0d ch%0d snap", tag, d, c), 32'(snapv[d][c*CNT_W +: CNT_W]), m_snap[d][c]);
        chk($sformatf("%s d%0d ch%0d dir", tag, d, c), 32'(dirv[d][c]), m_dir[d][c]);
        chk($sformatf("%s d%0d ch%0d ovf", tag, d, c), 32'(ovfv[d][c]), m_ovf[d][c]);
        chk($sformatf("%s d%0d ch%0d err", tag, d, c), 32'(errv[d][c]), m_err[d][c]);
      end
  endtask

  initial begin
    int peak;
    int seen;
    int r;
    int ch;
    int len;
    logic [1:0] st;

    init_v = '{128, 254, 254};
    sat_v  = '{0, 0, 1};
    reset_ = 1'b1; qa = '0; qb = '0; clr = '0; snap = 1'b0;

    // asynchronous reset asserted mid-clock
    #5 reset_ = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    tick(2);
    reset_ = 1'b1;
    tick(10);
    check_all("post_reset");

    // up count on ch0
    for (int i = 0; i < 4; i++) begin
      set_ch(0, up_seq[i]);
      tick(10);
      model_move(0, up_seq[i]);
      check_all("up");
    end
    chk("up ch0 value", 32'(live[0][0 +: CNT_W]), 132);
    chk("up ch0 dir", 32'(dirv[0][0]), 1);
    chk("up ch1 idle", 32'(live[0][CNT_W +: CNT_W]), 128);

    // wrap and saturate on ch1 from a fresh clear
    pulse_clr(2'b11);
    model_clr(3);
    check_all("clr_all");
    for (int i = 0; i < 3; i++) begin
      set_ch(1, up_seq[i]);
      tick(10);
      model_move(1, up_seq[i]);
      check_all("wrapsat");
      chk("wrap ch1 value", 32'(live[1][CNT_W +: CNT_W]), wrap_exp[i]);
      chk("sat ch1 value", 32'(live[2][CNT_W +: CNT_W]), 255);
    end
    chk("wrap ovf", 32'(ovfv[1][1]), 1);
    chk("sat ovf", 32'(ovfv[2][1]), 1);
    pulse_clr(2'b10);
    model_clr(2);
    check_all("clr_ch1");
    chk("clr ch1 value", 32'(live[1][CNT_W +: CNT_W]), 254);
    chk("clr ch1 ovf", 32'(ovfv[1][1]), 0);

    // short pulse is filtered out
    qa[0] = 1'b1;
    tick(FILT_LEN - 1);
    qa[0] = 1'b0;
    tick(15);
    check_all("glitch_short");

    // pulse of exactly FILT_LEN cycles: +1 then -1
    model_move(0, 2'b01);
    peak = m_cnt[0][0];
    seen = 0;
    qa[0] = 1'b1;
    for (int i = 0; i < FILT_LEN; i++) begin
      tick(1);
      if (live[0][0 +: CNT_W] == CNT_W'(peak)) seen = 1;
    end
    qa[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (live[0][0 +: CNT_W] == CNT_W'(peak)) seen = 1;
    end
    model_move(0, 2'b00);
    chk("glitch_len peak seen", 32'(seen), 1);
    check_all("glitch_len");

    // illegal jump then legal steps
    set_ch(0, 2'b11); tick(12); model_move(0, 2'b11); check_all("illegal");
    chk("illegal err", 32'(errv[0][0]), 1);
    set_ch(0, 2'b10); tick(12); model_move(0, 2'b10); check_all("after_illegal1");
    set_ch(0, 2'b00); tick(12); model_move(0, 2'b00); check_all("after_illegal2");

    // snapshot coincident with a step, measured against the pipeline latency
    pulse_clr(2'b01);
    model_clr(1);
    set_ch(0, 2'b01); tick(10); model_move(0, 2'b01);
    set_ch(0, 2'b11); tick(10); model_move(0, 2'b11);
    chk("pre_snap ch0", 32'(live[0][0 +: CNT_W]), 130);
    set_ch(0, 2'b10);
    tick(FILT_LEN + 3);
    chk("latency hold", 32'(live[0][0 +: CNT_W]), 130);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    model_snap();
    model_move(0, 2'b10);
    check_all("snap_step");
    chk("snap_step snap", 32'(snapv[0][0 +: CNT_W]), 130);
    chk("snap_step live", 32'(live[0][0 +: CNT_W]), 131);
    tick(5);
    clr = 2'b01;
    snap = 1'b1;
    tick(1);
    clr = '0;
    snap = 1'b0;
    model_snap();
    model_clr(1);
    check_all("snap_clr");

    // randomized mix of steps, glitches, clears and snapshots
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        len = $urandom_range(1, 3);
        pulse_clr(NCH'(len));
        model_clr(len);
      end else if (r == 1) begin
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        model_snap();
      end else if (r == 2) begin
        ch = $urandom_range(0, NCH - 1);
        len = $urandom_range(1, FILT_LEN - 1);
        if ($urandom_range(0, 1) == 0) qa[ch] = ~qa[ch]; else qb[ch] = ~qb[ch];
        tick(len);
        set_ch(ch, m_st[ch]);
        tick(12);
      end else begin
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 1) == 1) set_ch(c, 2'($urandom_range(0, 3)));
        tick(12);
        for (int c = 0; c < NCH; c++) begin
          st = {qb[c], qa[c]};
          model_move(c, st);
        end
      end
      check_all("random");
    end

    // reset mid-rotation with arbitrary inputs applied
    for (int c = 0; c < NCH; c++) set_ch(c, 2'($urandom_range(1, 3)));
    #3 reset_ = 1'b0;
    #1;
    model_reset();
    check_all("reset_mid");
    @(negedge clk);
    reset_ = 1'b1;
    tick(15);
    for (int c = 0; c < NCH; c++) begin
      st = {qb[c], qa[c]};
      model_move(c, st);
    end
    check_all("after_reset_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
